apb_stim_master: RTL and testbench

//   APB master stimulus stage that sits directly upstream of the ECC encoder/decoder DUT and the

---
 rtl/apb_stim_master.sv | 123 ++++++++++++
 tb/tb_apb_stim_master.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/apb_stim_master.sv
// APB master stimulus stage: turns bench commands into APB SETUP/ACCESS cycles and
// reports completion, waiting on operation_done (or timing out) after control-register writes.
module apb_stim_master #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int DONE_TIMEOUT    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PWRITE,
  output logic                       PSEL,
  output logic                       PENABLE,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       operation_done,
  output logic                       rsp_valid,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       rsp_timeout
);

  localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETUP     = 2'd1,
    ACCESS    = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ctrl_addr_s;

  // The latched address decides whether the write targets the control register.
  assign ctrl_addr_s = (PADDR[3:0] == 4'h0);
  assign cmd_ready   = (state_r == IDLE);

  // Transaction sequencer: APB phases, completion wait and one-cycle response pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      PADDR       <= {AMBA_ADDR_WIDTH{1'b0}};
      PWDATA      <= {AMBA_WORD{1'b0}};
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= {AMBA_WORD{1'b0}};
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            PADDR   <= cmd_addr;
            PWDATA  <= cmd_wdata;
            PWRITE  <= cmd_write;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state_r <= SETUP;
          end else begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state_r <= ACCESS;
        end
        ACCESS: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          if (!PWRITE) begin
            rsp_rdata   <= PRDATA;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b0;
            state_r     <= IDLE;
          end else if (!ctrl_addr_s) begin
            rsp_rdata   <= {AMBA_WORD{1'b0}};
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b0;
            state_r     <= IDLE;
          end else begin
            cnt_r   <= CNT_ZERO;
            state_r <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // operation_done takes priority over the final timeout count.
          if (operation_done) begin
            rsp_rdata   <= {AMBA_WORD{1'b0}};
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b0;
            state_r     <= IDLE;
          end else if (cnt_r == CNT_LAST) begin
            rsp_rdata   <= {AMBA_WORD{1'b0}};
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            state_r     <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_stim_master.sv
// Directed testbench for apb_stim_master: APB phase timing, reads, control-write
// completion/timeout, back-to-back commands and asynchronous reset behaviour.
module tb_apb_stim_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [19:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        operation_done;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;

  int checks = 0;
  int passes = 0;

  apb_stim_master #(.AMBA_ADDR_WIDTH(20), .AMBA_WORD(32), .DONE_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .operation_done(operation_done), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command in IDLE; returns in the SETUP cycle with cmd_valid dropped.
  task automatic start_cmd(input logic w, input logic [19:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_power_on();
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 20'h0; cmd_wdata = 32'h0;
    PRDATA = 32'h0; operation_done = 1'b0;
    tick(); tick();
    checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0) begin $display("FAIL por_outputs: got psel=%0b pen=%0b rv=%0b want 0", PSEL, PENABLE, rsp_valid); end else passes++;
    rst = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin $display("FAIL por_ready: got %0b want 1", cmd_ready); end else passes++;
  endtask

  task automatic test_write();
    start_cmd(1'b1, 20'h00004, 32'hDEADBEEF);
    cmd_addr = 20'hFFFFF; cmd_wdata = 32'h0; cmd_write = 1'b0;
    checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin $display("FAIL wr_setup_phase: got psel=%0b pen=%0b want 1/0", PSEL, PENABLE); end else passes++;
    checks++; if (PADDR !== 20'h00004 || PWRITE !== 1'b1) begin $display("FAIL wr_setup_addr: got %h/%0b want 00004/1", PADDR, PWRITE); end else passes++;
    checks++; if (PWDATA !== 32'hDEADBEEF) begin $display("FAIL wr_setup_data: got %h want deadbeef", PWDATA); end else passes++;
    checks++; if (cmd_ready !== 1'b0) begin $display("FAIL wr_busy_ready: got %0b want 0", cmd_ready); end else passes++;
    tick();
    checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== 20'h00004) begin $display("FAIL wr_access: got psel=%0b pen=%0b addr=%h want 1/1/00004", PSEL, PENABLE, PADDR); end else passes++;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin $display("FAIL wr_rsp: got rv=%0b to=%0b rd=%h want 1/0/0", rsp_valid, rsp_timeout, rsp_rdata); end else passes++;
    checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || cmd_ready !== 1'b1) begin $display("FAIL wr_idle: got psel=%0b pen=%0b rdy=%0b want 0/0/1", PSEL, PENABLE, cmd_ready); end else passes++;
    tick();
    checks++; if (rsp_valid !== 1'b0 || PADDR !== 20'h00004 || PWDATA !== 32'hDEADBEEF) begin $display("FAIL wr_after: got rv=%0b addr=%h data=%h want 0/00004/deadbeef", rsp_valid, PADDR, PWDATA); end else passes++;
  endtask

  task automatic test_read();
    PRDATA = 32'hBAD0BAD0;
    start_cmd(1'b0, 20'h00008, 32'h0);
    checks++; if (PWRITE !== 1'b0 || PADDR !== 20'h00008) begin $display("FAIL rd_setup: got wr=%0b addr=%h want 0/00008", PWRITE, PADDR); end else passes++;
    tick();
    PRDATA = 32'h12345678;
    tick();
    PRDATA = 32'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || rsp_timeout !== 1'b0) begin $display("FAIL rd_rsp: got rv=%0b rd=%h to=%0b want 1/12345678/0", rsp_valid, rsp_rdata, rsp_timeout); end else passes++;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin $display("FAIL rd_pulse: got %0b want 0", rsp_valid); end else passes++;
  endtask

  task automatic test_ctrl_done();
    start_cmd(1'b1, 20'h00000, 32'h1);
    tick();
    tick();
    checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin $display("FAIL ctrl_wait: got psel=%0b pen=%0b rdy=%0b rv=%0b want 0/0/0/0", PSEL, PENABLE, cmd_ready, rsp_valid); end else passes++;
    tick();
    tick();
    operation_done = 1'b1;
    tick();
    operation_done = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin $display("FAIL ctrl_done_rsp: got rv=%0b to=%0b rd=%h want 1/0/0", rsp_valid, rsp_timeout, rsp_rdata); end else passes++;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin $display("FAIL ctrl_done_pulse: got %0b want 0", rsp_valid); end else passes++;
  endtask

  task automatic test_timeout();
    start_cmd(1'b1, 20'h00010, 32'h2);
    tick();
    for (int i = 1; i <= 8; i++) tick();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin $display("FAIL to_last_wait: got rv=%0b rdy=%0b want 0/0", rsp_valid, cmd_ready); end else passes++;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1) begin $display("FAIL to_rsp: got rv=%0b to=%0b want 1/1", rsp_valid, rsp_timeout); end else passes++;
    tick();
    start_cmd(1'b1, 20'h00000, 32'h3);
    tick();
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 8) operation_done = 1'b1;
    end
    tick();
    operation_done = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0) begin $display("FAIL to_done_last: got rv=%0b to=%0b want 1/0", rsp_valid, rsp_timeout); end else passes++;
    tick();
  endtask

  task automatic test_back_to_back();
    start_cmd(1'b1, 20'h00014, 32'h55AA55AA);
    tick();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00028; cmd_wdata = 32'h0;
    PRDATA = 32'h0F0F0F0F;
    tick();
    checks++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b1 || PADDR !== 20'h00014) begin $display("FAIL b2b_first_rsp: got rv=%0b rdy=%0b addr=%h want 1/1/00014", rsp_valid, cmd_ready, PADDR); end else passes++;
    tick();
    cmd_valid = 1'b0;
    checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 20'h00028 || PWRITE !== 1'b0 || rsp_valid !== 1'b0) begin $display("FAIL b2b_second_setup: got psel=%0b pen=%0b addr=%h wr=%0b rv=%0b want 1/0/00028/0/0", PSEL, PENABLE, PADDR, PWRITE, rsp_valid); end else passes++;
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0F0F0F0F) begin $display("FAIL b2b_second_rsp: got rv=%0b rd=%h want 1/0f0f0f0f", rsp_valid, rsp_rdata); end else passes++;
    tick();
  endtask

  task automatic test_reset();
    start_cmd(1'b1, 20'h00024, 32'hCAFEF00D);
    rst = 1'b1;
    #1;
    checks++; if (PADDR !== 20'h0 || PWDATA !== 32'h0 || PWRITE !== 1'b0 || PSEL !== 1'b0 || PENABLE !== 1'b0) begin $display("FAIL rst_apb: got addr=%h data=%h wr=%0b psel=%0b pen=%0b want all 0", PADDR, PWDATA, PWRITE, PSEL, PENABLE); end else passes++;
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_timeout !== 1'b0) begin $display("FAIL rst_rsp: got rv=%0b rd=%h to=%0b want all 0", rsp_valid, rsp_rdata, rsp_timeout); end else passes++;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1 || PSEL !== 1'b0 || rsp_valid !== 1'b0) begin $display("FAIL rst_release: got rdy=%0b psel=%0b rv=%0b want 1/0/0", cmd_ready, PSEL, rsp_valid); end else passes++;
  endtask

  task automatic test_reset_abort();
    PRDATA = 32'h11112222;
    start_cmd(1'b0, 20'h00008, 32'h0);
    tick();
    checks++; if (PENABLE !== 1'b1) begin $display("FAIL abort_in_access: got pen=%0b want 1", PENABLE); end else passes++;
    rst = 1'b1;
    #1;
    checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0) begin $display("FAIL abort_drop: got psel=%0b pen=%0b rv=%0b want 0/0/0", PSEL, PENABLE, rsp_valid); end else passes++;
    #2;
    rst = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin $display("FAIL abort_no_rsp: got rv=%0b rdy=%0b want 0/1", rsp_valid, cmd_ready); end else passes++;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin $display("FAIL abort_no_rsp2: got %0b want 0", rsp_valid); end else passes++;
    PRDATA = 32'hA5A50001;
    start_cmd(1'b0, 20'h0002C, 32'h0);
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A50001 || rsp_timeout !== 1'b0) begin $display("FAIL abort_next_read: got rv=%0b rd=%h to=%0b want 1/a5a50001/0", rsp_valid, rsp_rdata, rsp_timeout); end else passes++;
    tick();
  endtask

  initial begin
    test_power_on();
    test_write();
    test_read();
    test_ctrl_done();
    test_timeout();
    test_back_to_back();
    test_reset();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
